alu_result_queue: RTL and testbench

- Downstream stage of the 4-bit ALU.
- Captures each ALU result (`ans`) together with the opcode that produced it and derives zero/negative flags at capture time.
- Buffers results in a small in-order FIFO.
- Presents them to the consumer (register file / display stage) over a valid/ready handshake, so a stalled consumer never loses an ALU result.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_rq_mem.sv | 24 ++
 rtl/alu_result_queue.sv | 93 +++++++++
 tb/tb_alu_result_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, default width and result-entry layout
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

    typedef struct packed {
        alu_op_e                op;
        logic [ALU_WIDTH-1:0]   ans;
        logic                   zero;
        logic                   neg;
    } alu_entry_t;

    // Bits an entry carries beyond the result itself: op, zero, neg.
    localparam int ENTRY_META_W = $bits(alu_entry_t) - ALU_WIDTH;

endpackage

// File: rtl/alu_rq_mem.sv
// rtl/alu_rq_mem.sv - entry storage: one write port, asynchronous read, no reset
module alu_rq_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] storage [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            storage[wrAddr] <= wrData;
        end
    end

    assign rdData = storage[rdAddr];

endmodule

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - in-order ALU result queue with valid/ready output
// Define ALU_RESULT_QUEUE_BYPASS_EN for a same-cycle path when the queue is empty.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_ans,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [WIDTH-1:0]         out_ans,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRY_W = WIDTH + ENTRY_META_W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]      wrPtr, rdPtr;
    logic [CW-1:0]      occupancy;
    logic [ENTRY_W-1:0] inEntry, memEntry, headEntry;
    logic               inZero, inNeg;
    logic               push, queueValid, wrEn, rdEn;

    assign inZero  = (in_ans == '0);
    assign inNeg   = in_ans[WIDTH-1];
    assign inEntry = {in_op, in_ans, inZero, inNeg};

    // No pass-through when full: readiness looks only at registered occupancy.
    assign in_ready   = rst_n && (occupancy < FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign queueValid = (occupancy != '0);
    assign rdEn       = queueValid && out_ready;

`ifdef ALU_RESULT_QUEUE_BYPASS_EN
    logic bypassHit;
    assign bypassHit = !queueValid && push;
    assign out_valid = queueValid || bypassHit;
    assign headEntry = queueValid ? memEntry : inEntry;
    // A bypassed entry taken in the same cycle is never stored.
    assign wrEn      = push && !(bypassHit && out_ready);
`else
    assign out_valid = queueValid;
    assign headEntry = memEntry;
    assign wrEn      = push;
`endif

    assign {out_op, out_ans, out_zero, out_neg} = out_valid ? headEntry : '0;
    assign count = occupancy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    alu_rq_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrPtr),
        .wrData (inEntry),
        .rdAddr (rdPtr),
        .rdData (memEntry)
    );

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - directed self-checking bench for alu_result_queue
module tb_alu_result_queue;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_ans;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [3:0] out_ans;
    logic       out_zero;
    logic       out_neg;
    logic [2:0] count;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    alu_result_queue #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ans    (in_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_ans   (out_ans),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .count     (count)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [1:0] op, input logic [3:0] ans,
                             input logic zero, input logic neg);
        checkVal({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkVal({tag, ".op"},    32'(out_op),    32'(op));
        checkVal({tag, ".ans"},   32'(out_ans),   32'(ans));
        checkVal({tag, ".zero"},  32'(out_zero),  32'(zero));
        checkVal({tag, ".neg"},   32'(out_neg),   32'(neg));
    endtask

    task automatic pushOne(input logic [1:0] op, input logic [3:0] ans);
        in_valid = 1'b1;
        in_op    = op;
        in_ans   = ans;
        step();
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_ans = 4'h0;
        out_ready = 1'b0;

        // reset state
        step();
        step();
        checkVal("rst.in_ready", 32'(in_ready), 32'd0);
        checkVal("rst.count", 32'(count), 32'd0);
        checkVal("rst.out_valid", 32'(out_valid), 32'd0);
        checkVal("rst.out_ans", 32'(out_ans), 32'd0);
        rst_n = 1'b1;
        #1;
        checkVal("idle.in_ready", 32'(in_ready), 32'd1);
        step();
        checkVal("idle.count", 32'(count), 32'd0);
        checkVal("idle.out_valid", 32'(out_valid), 32'd0);

        // flags on push, then order after pop
        pushOne(OP_ADD, 4'hF);
        checkVal("lat1.count", 32'(count), 32'd1);
        checkHead("addF", 2'b11, 4'hF, 1'b0, 1'b1);
        pushOne(OP_AND, 4'h0);
        checkVal("two.count", 32'(count), 32'd2);
        checkHead("addF_hold", 2'b11, 4'hF, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checkHead("and0", 2'b00, 4'h0, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checkVal("empty.out_valid", 32'(out_valid), 32'd0);
        checkVal("empty.out_op", 32'(out_op), 32'd0);
        checkVal("empty.out_neg", 32'(out_neg), 32'd0);

        // fill to full from a fresh reset
        doReset();
        pushOne(OP_OR,  4'h1);
        pushOne(OP_XOR, 4'h2);
        pushOne(OP_ADD, 4'h3);
        pushOne(OP_AND, 4'h4);
        checkVal("full.count", 32'(count), 32'd4);
        checkVal("full.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_op = OP_ADD;
        in_ans = 4'hE;
        step();
        step();
        in_valid = 1'b0;
        #1;
        checkVal("fifth.count", 32'(count), 32'd4);
        out_ready = 1'b1;
        #1;
        checkVal("full_pop.in_ready", 32'(in_ready), 32'd0);
        checkHead("pop1", 2'b01, 4'h1, 1'b0, 1'b0);
        step();
        checkHead("pop2", 2'b10, 4'h2, 1'b0, 1'b0);
        step();
        checkHead("pop3", 2'b11, 4'h3, 1'b0, 1'b0);
        step();
        checkHead("pop4", 2'b00, 4'h4, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        #1;
        checkVal("drained.count", 32'(count), 32'd0);
        pushOne(OP_XOR, 4'hA);
        checkVal("sixth.count", 32'(count), 32'd1);
        checkHead("sixth", 2'b10, 4'hA, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // steady push/pop at count 2
        pushOne(2'd0, 4'd0);
        pushOne(2'd1, 4'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op = 2'((i + 2) % 4);
            in_ans = 4'(i + 2);
            out_ready = 1'b1;
            #1;
            checkVal($sformatf("stream%0d.count", i), 32'(count), 32'd2);
            checkVal($sformatf("stream%0d.ans", i), 32'(out_ans), 32'(i));
            checkVal($sformatf("stream%0d.op", i), 32'(out_op), 32'(i % 4));
            step();
        end
        in_valid = 1'b0;
        #1;
        checkVal("tail0.ans", 32'(out_ans), 32'd10);
        step();
        checkVal("tail1.ans", 32'(out_ans), 32'd11);
        step();
        out_ready = 1'b0;
        #1;
        checkVal("stream_end.count", 32'(count), 32'd0);

        // reset with entries queued
        pushOne(OP_AND, 4'h7);
        pushOne(OP_OR,  4'h9);
        pushOne(OP_ADD, 4'hC);
        checkVal("pre_rst.count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step();
        checkVal("mid_rst.count", 32'(count), 32'd0);
        checkVal("mid_rst.out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        pushOne(OP_XOR, 4'h5);
        checkHead("post_rst", 2'b10, 4'h5, 1'b0, 1'b0);
        checkVal("post_rst.count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checkVal("post_rst_drain.count", 32'(count), 32'd0);

        // empty-queue push with consumer ready
        in_valid = 1'b1;
        in_op = OP_OR;
        in_ans = 4'h8;
        out_ready = 1'b1;
        #1;
`ifdef ALU_RESULT_QUEUE_BYPASS_EN
        checkHead("bypass_same", 2'b01, 4'h8, 1'b0, 1'b1);
`else
        checkVal("nobypass_same.out_valid", 32'(out_valid), 32'd0);
`endif
        step();
        in_valid = 1'b0;
        #1;
`ifdef ALU_RESULT_QUEUE_BYPASS_EN
        checkVal("bypass_next.count", 32'(count), 32'd0);
        checkVal("bypass_next.out_valid", 32'(out_valid), 32'd0);
`else
        checkVal("nobypass_next.count", 32'(count), 32'd1);
        checkHead("nobypass_next", 2'b01, 4'h8, 1'b0, 1'b1);
`endif
        step();
        out_ready = 1'b0;
        #1;
        checkVal("final.count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
